dcache_port_arbiter: RTL and testbench
======================================

# dcache_port_arbiter

Shares one data-cache request port among `NR_PORTS` requesters (load unit, store buffer, PTW) in the LSU. It arbitrates round-robin and holds a grant until the cache accepts the request. It forwards the late tag phase from the previously granted requester and routes read responses back in order through a small ID FIFO. It sits between the LSU requesters and a single `dcache_req_i_t` / `dcache_req_o_t` port.

## Interface
- `NR_PORTS`, 3, number of requesters (2..8).
- `RSP_DEPTH`, 4, maximum outstanding granted reads (power of two, ≥2).
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  drops a pending (ungranted) lock.
- `req_ports_i`  in  `NR_PORTS` x `dcache_req_i_t`  requester requests.
- `req_ports_o`  out  `NR_PORTS` x `dcache_req_o_t`  per-requester `data_gnt`, `data_rvalid`, `data_rdata`.
- `req_port_o`  out  `dcache_req_i_t`  request to the D$.
- `req_port_i`  in  `dcache_req_o_t`  D$ response.
- `busy_o`  out  1  lock held or reads outstanding.

## Operation
**States**
- IDLE: winner = first requester with `data_req` searching from `rr_q` upward, wrapping at `NR_PORTS`. A read request is masked while the FIFO is full.
- LOCKED: `locked_id_q` is selected unconditionally.

**Request phase**
- The winner's `address_index`, `data_wdata`, `data_we`, `data_be`, `data_size`, and `data_req` drive `req_port_o`.
- When `req_port_i.data_gnt` = 1, `data_gnt` is forwarded to the winner only, and:
  - `rr_q` ← winner+1 mod `NR_PORTS`;
  - `tag_id_q` ← winner and `tag_vld_q` ← 1;
  - for a read (`!data_we`), the winner ID is pushed into the FIFO;
  - the state goes to IDLE.
- When `data_req` = 1 and `data_gnt` = 0: IDLE → LOCKED with `locked_id_q` ← winner.
- If the locked requester drops `data_req`, LOCKED → IDLE with no grant and no push.
- `flush_i` forces IDLE. It does not clear the FIFO, `rr_q`, or `tag_*_q`.

**Tag phase**
- In the cycle after a grant (`tag_vld_q`), `address_tag`, `tag_valid`, and `kill_req` come from requester `tag_id_q`.
- Otherwise these fields are 0.

**Responses**
- The D$ returns exactly one `data_rvalid` per granted read, including killed reads.
- `data_rvalid` is routed to the FIFO head ID, which is then popped.
- `data_rdata` is broadcast to all ports.
- An `rvalid` with the FIFO empty is ignored, and a simulation assertion fires.

**Other**
- Write grants never touch the FIFO.
- `busy_o` = LOCKED | FIFO non-empty.

## Timing
- Request and grant paths are combinational, with zero added latency. `data_gnt` to the requester arrives in the same cycle as `req_port_i.data_gnt`.
- The tag phase is forwarded exactly one cycle after the grant. A new request may be granted in the same cycle as the tag phase.
- The full-mask uses the registered count, so a pop in the same cycle does not unmask a read.
- Push and pop in the same cycle leave the count unchanged. The pointers wrap mod `RSP_DEPTH`.
- Reset values:
  - all `req_port_o` fields 0;
  - all `req_ports_o` fields 0;
  - `busy_o` = 0;
  - `rr_q` = 0, state IDLE, FIFO empty, `tag_vld_q` = 0.
- Reset mid-transaction discards the lock and all outstanding IDs.

## Configuration
- `DCACHE_ARB_PRIO_EN`, defined: in IDLE, port 0 wins whenever it requests, ahead of the round-robin search. `rr_q` is not updated on a port-0 grant. LOCKED still has precedence.
- Not defined: pure round-robin for all ports.

## Test plan
- Ports 0, 1, 2 request reads continuously and D$ grants every cycle → grants go 0, 1, 2, 0, … (without the macro). The FIFO order matches, and each `rvalid` goes to the matching port.
- Port 1 requests with `gnt` held low for 3 cycles while port 2 also requests → port 1 stays on `req_port_o` for all 4 cycles. Port 2 is granted the next cycle.
- Port 0 is granted a read at cycle 5; port 0 drives `address_tag` = 0x1234 with `tag_valid` at cycle 6 while port 2 is granted at cycle 6 → `req_port_o.address_tag` = 0x1234 at cycle 6.
- Four reads are granted with `RSP_DEPTH` = 4 and no `rvalid` → a fifth read request is masked and a write from another port is still granted. One `rvalid` pops the head, and the read is granted the following cycle.
- `flush_i` is pulsed while port 2 is LOCKED → the state is IDLE next cycle. Outstanding `rvalid`s are still routed correctly, and `busy_o` falls once the FIFO is empty.
- With `DCACHE_ARB_PRIO_EN`, ports 0 and 1 request continuously → port 0 wins every IDLE arbitration. Port 1 is granted only when port 0 deasserts.

Source files
------------

// File: rtl/dcache_port_arbiter.sv
// ---------------------------------------------------------------------------
// dcache_port_arbiter
//
// Shares a single data-cache request port among NR_PORTS LSU requesters
// (load unit, store buffer, PTW). Requests are arbitrated round-robin and a
// grant is held (LOCKED) until the cache accepts it. The late tag phase is
// forwarded from the requester granted in the previous cycle. Read responses
// are returned in order through a small FIFO of granted requester IDs.
//
// Parameters:
//   NR_PORTS   number of requesters (2..8)
//   RSP_DEPTH  maximum outstanding granted reads (power of two, >= 2)
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   flush_i      drops a pending (ungranted) lock
//   req_ports_i  per-requester requests
//   req_ports_o  per-requester data_gnt / data_rvalid / data_rdata
//   req_port_o   request towards the D$
//   req_port_i   response from the D$
//   busy_o       lock held or reads outstanding
//
// Build option:
//   DCACHE_ARB_PRIO_EN  when defined, port 0 wins every IDLE arbitration in
//                       which it requests, ahead of the round-robin search,
//                       and its grants leave the round-robin pointer alone.
// ---------------------------------------------------------------------------

package dcache_arb_pkg;

  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 20;
  localparam int unsigned DCACHE_DATA_WIDTH  = 32;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0]  address_index;
    logic [DCACHE_TAG_WIDTH-1:0]    address_tag;
    logic [DCACHE_DATA_WIDTH-1:0]   data_wdata;
    logic                           data_req;
    logic                           data_we;
    logic [DCACHE_DATA_WIDTH/8-1:0] data_be;
    logic [1:0]                     data_size;
    logic                           kill_req;
    logic                           tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic                         data_gnt;
    logic                         data_rvalid;
    logic [DCACHE_DATA_WIDTH-1:0] data_rdata;
  } dcache_req_o_t;

endpackage

module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int unsigned NR_PORTS  = 3,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  dcache_req_i_t [NR_PORTS-1:0] req_ports_i,
  output dcache_req_o_t [NR_PORTS-1:0] req_ports_o,
  output dcache_req_i_t                req_port_o,
  input  dcache_req_o_t                req_port_i,
  output logic                         busy_o
);

  localparam int unsigned IdW  = $clog2(NR_PORTS);
  localparam int unsigned PtrW = $clog2(RSP_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [IdW-1:0] port_id_t;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e          state_q, state_d;
  port_id_t        locked_id_q, locked_id_d;
  port_id_t        rr_q, rr_d;
  port_id_t        tag_id_q, tag_id_d;
  logic            tag_vld_q, tag_vld_d;

  port_id_t        fifo_q [RSP_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;

  logic                fifo_full, fifo_empty;
  logic                push, pop;
  logic [NR_PORTS-1:0] eligible;
  port_id_t            winner;
  logic                win_vld;
  logic                gnt_fire;
  port_id_t            winner_inc;

  assign fifo_full  = (cnt_q == CntW'(RSP_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign busy_o     = (state_q == LOCKED) | ~fifo_empty;

  // A read cannot be accepted while every response slot is taken; the
  // registered count is used so a same-cycle pop does not unmask it.
  always_comb begin
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      eligible[i] = req_ports_i[i].data_req & (req_ports_i[i].data_we | ~fifo_full);
    end
  end

  // Round-robin search from rr_q; walking the offsets downwards lets the
  // closest eligible requester be the last (winning) assignment.
  always_comb begin
    int       idx;
    port_id_t cand;
    winner  = '0;
    win_vld = 1'b0;
    idx     = 0;
    cand    = '0;
    if (state_q == LOCKED) begin
      winner  = locked_id_q;
      win_vld = req_ports_i[locked_id_q].data_req;
    end else begin
      for (int off = NR_PORTS - 1; off >= 0; off--) begin
        idx = int'(rr_q) + off;
        if (idx >= int'(NR_PORTS)) begin
          idx = idx - int'(NR_PORTS);
        end
        cand = port_id_t'(idx);
        if (eligible[cand]) begin
          winner  = cand;
          win_vld = 1'b1;
        end
      end
`ifdef DCACHE_ARB_PRIO_EN
      if (eligible[0]) begin
        winner  = '0;
        win_vld = 1'b1;
      end
`endif
    end
  end

  assign gnt_fire   = win_vld & req_port_i.data_gnt;
  assign push       = gnt_fire & ~req_ports_i[winner].data_we;
  assign pop        = req_port_i.data_rvalid & ~fifo_empty;
  assign winner_inc = (winner == port_id_t'(NR_PORTS - 1)) ? '0 : winner + port_id_t'(1);

  // Request fields come from the current winner; tag-phase fields come from
  // whoever was granted one cycle earlier, independently of the new winner.
  always_comb begin
    req_port_o = '0;
    if (win_vld) begin
      req_port_o.address_index = req_ports_i[winner].address_index;
      req_port_o.data_wdata    = req_ports_i[winner].data_wdata;
      req_port_o.data_we       = req_ports_i[winner].data_we;
      req_port_o.data_be       = req_ports_i[winner].data_be;
      req_port_o.data_size     = req_ports_i[winner].data_size;
      req_port_o.data_req      = 1'b1;
    end
    if (tag_vld_q) begin
      req_port_o.address_tag = req_ports_i[tag_id_q].address_tag;
      req_port_o.tag_valid   = req_ports_i[tag_id_q].tag_valid;
      req_port_o.kill_req    = req_ports_i[tag_id_q].kill_req;
    end
  end

  // Read data is broadcast; only the FIFO head sees data_rvalid.
  always_comb begin
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      req_ports_o[i]            = '0;
      req_ports_o[i].data_rdata = req_port_i.data_rdata;
    end
    if (gnt_fire) begin
      req_ports_o[winner].data_gnt = 1'b1;
    end
    if (pop) begin
      req_ports_o[fifo_q[rd_ptr_q]].data_rvalid = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    locked_id_d = locked_id_q;
    rr_d        = rr_q;
    tag_id_d    = tag_id_q;
    tag_vld_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld && !req_port_i.data_gnt) begin
          state_d     = LOCKED;
          locked_id_d = winner;
        end
      end
      LOCKED: begin
        if (!win_vld || req_port_i.data_gnt) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (gnt_fire) begin
      tag_id_d  = winner;
      tag_vld_d = 1'b1;
`ifdef DCACHE_ARB_PRIO_EN
      if (winner != '0) begin
        rr_d = winner_inc;
      end
`else
      rr_d = winner_inc;
`endif
    end
    // Flush only abandons an ungranted lock; outstanding reads stay tracked.
    if (flush_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      locked_id_q <= '0;
      rr_q        <= '0;
      tag_id_q    <= '0;
      tag_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      locked_id_q <= locked_id_d;
      rr_q        <= rr_d;
      tag_id_q    <= tag_id_d;
      tag_vld_q   <= tag_vld_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= winner;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni && req_port_i.data_rvalid) begin
      assert (!fifo_empty)
        else $error("dcache_port_arbiter: data_rvalid with no outstanding read");
    end
  end
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dcache_port_arbiter
//
// Directed scoreboard bench for dcache_port_arbiter (NR_PORTS=3,
// RSP_DEPTH=4, default build). Stimulus pushes expected grants, routed
// responses and sampled request-port fields into queues; a monitor on the
// falling clock edge pops and compares them against what the DUT presents.
// ---------------------------------------------------------------------------

module tb_dcache_port_arbiter;
  import dcache_arb_pkg::*;

  localparam int NP = 3;

  localparam int K_BUSY    = 0;
  localparam int K_IDX     = 1;
  localparam int K_REQ     = 2;
  localparam int K_WE      = 3;
  localparam int K_TAG     = 4;
  localparam int K_TAGV    = 5;
  localparam int K_KILL    = 6;
  localparam int K_OUTZERO = 7;

  logic                   clk_i   = 1'b0;
  logic                   rst_ni  = 1'b0;
  logic                   flush_i = 1'b0;
  dcache_req_i_t [NP-1:0] req_ports_i;
  dcache_req_o_t [NP-1:0] req_ports_o;
  dcache_req_i_t          req_port_o;
  dcache_req_o_t          req_port_i;
  logic                   busy_o;

  dcache_port_arbiter #(
    .NR_PORTS  (NP),
    .RSP_DEPTH (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .req_ports_i (req_ports_i),
    .req_ports_o (req_ports_o),
    .req_port_o  (req_port_o),
    .req_port_i  (req_port_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { int cyc; int port; } gnt_exp_t;
  typedef struct { int cyc; int port; logic [31:0] data; } rv_exp_t;
  typedef struct { int cyc; int kind; logic [31:0] val; } fld_exp_t;

  gnt_exp_t gntQ[$];
  rv_exp_t  rvQ[$];
  fld_exp_t fldQ[$];

  int total = 0;
  int bad   = 0;

  function automatic string kindName(input int kind);
    case (kind)
      K_BUSY:    return "busy_o";
      K_IDX:     return "address_index";
      K_REQ:     return "data_req";
      K_WE:      return "data_we";
      K_TAG:     return "address_tag";
      K_TAGV:    return "tag_valid";
      K_KILL:    return "kill_req";
      K_OUTZERO: return "outputs_nonzero";
      default:   return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] fieldValue(input int kind);
    case (kind)
      K_BUSY:    return {31'b0, busy_o};
      K_IDX:     return {20'b0, req_port_o.address_index};
      K_REQ:     return {31'b0, req_port_o.data_req};
      K_WE:      return {31'b0, req_port_o.data_we};
      K_TAG:     return {12'b0, req_port_o.address_tag};
      K_TAGV:    return {31'b0, req_port_o.tag_valid};
      K_KILL:    return {31'b0, req_port_o.kill_req};
      K_OUTZERO: return {31'b0, (|req_port_o) | (|req_ports_o)};
      default:   return 32'hdead_beef;
    endcase
  endfunction

  // Monitor: compares everything the DUT presents against the queues.
  always @(negedge clk_i) begin
    gnt_exp_t g;
    rv_exp_t  r;
    fld_exp_t f;
    for (int p = 0; p < NP; p++) begin
      if (req_ports_o[p].data_gnt) begin
        total++;
        if (gntQ.size() > 0 && gntQ[0].cyc == cyc) begin
          g = gntQ.pop_front();
          if (g.port != p) begin
            bad++;
            $display("[TB] FAIL gnt cycle %0d: got port %0d, want port %0d", cyc, p, g.port);
          end
        end else begin
          bad++;
          $display("[TB] FAIL gnt_unexpected cycle %0d: got port %0d, want none", cyc, p);
        end
      end
      if (req_ports_o[p].data_rvalid) begin
        total++;
        if (rvQ.size() > 0 && rvQ[0].cyc == cyc) begin
          r = rvQ.pop_front();
          if (r.port != p || req_ports_o[p].data_rdata !== r.data) begin
            bad++;
            $display("[TB] FAIL rvalid cycle %0d: got port %0d data 0x%0h, want port %0d data 0x%0h",
                     cyc, p, req_ports_o[p].data_rdata, r.port, r.data);
          end
        end else begin
          bad++;
          $display("[TB] FAIL rvalid_unexpected cycle %0d: got port %0d, want none", cyc, p);
        end
      end
    end
    while (gntQ.size() > 0 && gntQ[0].cyc <= cyc) begin
      g = gntQ.pop_front();
      total++;
      bad++;
      $display("[TB] FAIL gnt_missing cycle %0d: got none, want port %0d", g.cyc, g.port);
    end
    while (rvQ.size() > 0 && rvQ[0].cyc <= cyc) begin
      r = rvQ.pop_front();
      total++;
      bad++;
      $display("[TB] FAIL rvalid_missing cycle %0d: got none, want port %0d", r.cyc, r.port);
    end
    while (fldQ.size() > 0 && fldQ[0].cyc <= cyc) begin
      f = fldQ.pop_front();
      total++;
      if (fieldValue(f.kind) !== f.val) begin
        bad++;
        $display("[TB] FAIL %s cycle %0d: got 0x%0h, want 0x%0h",
                 kindName(f.kind), cyc, fieldValue(f.kind), f.val);
      end
    end
  end

  // Drives one cycle of requester valid/we and D$ response, just after the edge.
  task automatic applyStimulus(input logic [2:0] req, input logic [2:0] we,
                               input logic gnt, input logic rv, input logic [31:0] rdata);
    @(posedge clk_i);
    #1;
    for (int p = 0; p < NP; p++) begin
      req_ports_i[p].data_req = req[p];
      req_ports_i[p].data_we  = we[p];
    end
    req_port_i.data_gnt    = gnt;
    req_port_i.data_rvalid = rv;
    req_port_i.data_rdata  = rdata;
    flush_i                = 1'b0;
  endtask

  task automatic setTag(input int p, input logic [19:0] tag, input logic tv, input logic kill);
    req_ports_i[p].address_tag = tag;
    req_ports_i[p].tag_valid   = tv;
    req_ports_i[p].kill_req    = kill;
  endtask

  task automatic checkOutput(input int kind, input logic [31:0] val);
    fldQ.push_back('{cyc, kind, val});
  endtask

  task automatic expectGnt(input int p);
    gntQ.push_back('{cyc, p});
  endtask

  task automatic expectRv(input int p, input logic [31:0] d);
    rvQ.push_back('{cyc, p, d});
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      req_ports_i[p]               = '0;
      req_ports_i[p].address_index = 12'(256 + p);
      req_ports_i[p].data_wdata    = 32'(p + 1);
      req_ports_i[p].data_be       = 4'hf;
      req_ports_i[p].data_size     = 2'd2;
    end
    req_port_i = '0;

    // reset state
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
    checkOutput(K_BUSY, 0);
    checkOutput(K_OUTZERO, 0);
    checkOutput(K_REQ, 0);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
    rst_ni = 1'b1;
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
    checkOutput(K_BUSY, 0);

    // round-robin among three continuous readers
    applyStimulus(3'b111, 3'b000, 1'b1, 1'b0, 32'h0);
    expectGnt(0); checkOutput(K_IDX, 256);
    applyStimulus(3'b111, 3'b000, 1'b1, 1'b1, 32'hA000_0001);
    expectGnt(1); expectRv(0, 32'hA000_0001); checkOutput(K_IDX, 257);
    applyStimulus(3'b111, 3'b000, 1'b1, 1'b1, 32'hA000_0002);
    expectGnt(2); expectRv(1, 32'hA000_0002); checkOutput(K_IDX, 258);
    applyStimulus(3'b111, 3'b000, 1'b1, 1'b1, 32'hA000_0003);
    expectGnt(0); expectRv(2, 32'hA000_0003);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 32'hA000_0004);
    expectRv(0, 32'hA000_0004); checkOutput(K_BUSY, 1); checkOutput(K_REQ, 0);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
    checkOutput(K_BUSY, 0);

    // write grant leaves the FIFO empty, moves rr to 2
    applyStimulus(3'b010, 3'b010, 1'b1, 1'b0, 32'h0);
    expectGnt(1); checkOutput(K_WE, 1);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
    checkOutput(K_BUSY, 0);

    // port 1 locked for 3 stalled cycles while port 2 also requests
    applyStimulus(3'b010, 3'b000, 1'b0, 1'b0, 32'h0);
    checkOutput(K_IDX, 257); checkOutput(K_REQ, 1);
    applyStimulus(3'b110, 3'b000, 1'b0, 1'b0, 32'h0);
    checkOutput(K_IDX, 257); checkOutput(K_BUSY, 1);
    applyStimulus(3'b110, 3'b000, 1'b0, 1'b0, 32'h0);
    checkOutput(K_IDX, 257);
    applyStimulus(3'b110, 3'b000, 1'b1, 1'b0, 32'h0);
    expectGnt(1); checkOutput(K_IDX, 257);
    applyStimulus(3'b100, 3'b000, 1'b1, 1'b0, 32'h0);
    expectGnt(2); checkOutput(K_IDX, 258);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 32'hC000_0001);
    expectRv(1, 32'hC000_0001);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 32'hC000_0002);
    expectRv(2, 32'hC000_0002);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
    checkOutput(K_BUSY, 0);

    // tag phase forwarded from the previous grant during a new grant
    applyStimulus(3'b001, 3'b000, 1'b1, 1'b0, 32'h0);
    setTag(0, 20'h01234, 1'b1, 1'b1);
    setTag(2, 20'h00555, 1'b0, 1'b0);
    expectGnt(0); checkOutput(K_TAG, 0); checkOutput(K_TAGV, 0);
    applyStimulus(3'b100, 3'b000, 1'b1, 1'b0, 32'h0);
    expectGnt(2); checkOutput(K_TAG, 32'h1234); checkOutput(K_TAGV, 1);
    checkOutput(K_KILL, 1); checkOutput(K_IDX, 258);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 32'hD000_0001);
    expectRv(0, 32'hD000_0001); checkOutput(K_TAG, 32'h555);
    checkOutput(K_TAGV, 0); checkOutput(K_KILL, 0);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 32'hD000_0002);
    expectRv(2, 32'hD000_0002); checkOutput(K_TAG, 0);
    setTag(0, 20'h0, 1'b0, 1'b0);
    setTag(2, 20'h0, 1'b0, 1'b0);

    // FIFO full: read masked, write still granted, pop does not unmask same cycle
    applyStimulus(3'b001, 3'b000, 1'b1, 1'b0, 32'h0); expectGnt(0);
    applyStimulus(3'b010, 3'b000, 1'b1, 1'b0, 32'h0); expectGnt(1);
    applyStimulus(3'b100, 3'b000, 1'b1, 1'b0, 32'h0); expectGnt(2);
    applyStimulus(3'b001, 3'b000, 1'b1, 1'b0, 32'h0); expectGnt(0);
    applyStimulus(3'b110, 3'b100, 1'b1, 1'b0, 32'h0);
    expectGnt(2); checkOutput(K_WE, 1); checkOutput(K_IDX, 258); checkOutput(K_BUSY, 1);
    applyStimulus(3'b010, 3'b000, 1'b1, 1'b1, 32'hE000_0001);
    expectRv(0, 32'hE000_0001); checkOutput(K_REQ, 0);
    applyStimulus(3'b010, 3'b000, 1'b1, 1'b0, 32'h0);
    expectGnt(1);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 32'hE000_0002); expectRv(1, 32'hE000_0002);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 32'hE000_0003); expectRv(2, 32'hE000_0003);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 32'hE000_0004); expectRv(0, 32'hE000_0004);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 32'hE000_0005); expectRv(1, 32'hE000_0005);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
    checkOutput(K_BUSY, 0);

    // flush while port 2 is locked, with a read outstanding
    applyStimulus(3'b001, 3'b000, 1'b1, 1'b0, 32'h0);
    expectGnt(0);
    applyStimulus(3'b100, 3'b000, 1'b0, 1'b0, 32'h0);
    checkOutput(K_IDX, 258); checkOutput(K_BUSY, 1);
    applyStimulus(3'b100, 3'b000, 1'b0, 1'b0, 32'h0);
    flush_i = 1'b1;
    checkOutput(K_IDX, 258);
    applyStimulus(3'b010, 3'b000, 1'b1, 1'b0, 32'h0);
    expectGnt(1); checkOutput(K_IDX, 257);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 32'hF000_0001);
    expectRv(0, 32'hF000_0001);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 32'hF000_0002);
    expectRv(1, 32'hF000_0002); checkOutput(K_BUSY, 1);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
    checkOutput(K_BUSY, 0);

    // reset in the middle of a lock with a read outstanding
    applyStimulus(3'b001, 3'b000, 1'b1, 1'b0, 32'h0);
    expectGnt(0);
    applyStimulus(3'b010, 3'b000, 1'b0, 1'b0, 32'h0);
    checkOutput(K_BUSY, 1);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
    rst_ni = 1'b0;
    checkOutput(K_BUSY, 0); checkOutput(K_OUTZERO, 0);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
    rst_ni = 1'b1;
    checkOutput(K_BUSY, 0);
    applyStimulus(3'b100, 3'b000, 1'b0, 1'b0, 32'h0);
    checkOutput(K_IDX, 258); checkOutput(K_REQ, 1);
    applyStimulus(3'b100, 3'b000, 1'b1, 1'b0, 32'h0);
    expectGnt(2);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 32'h9000_0001);
    expectRv(2, 32'h9000_0001);
    applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
    checkOutput(K_BUSY, 0);

    repeat (3) @(posedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
